// File: rtl/shift_pkg.sv
// shift_pkg: shared operation encoding for the pipelined barrel shifter.
package shift_pkg;
  typedef enum logic [1:0] {SHIFT_SRL, SHIFT_SRA, SHIFT_SLL, SHIFT_ROR} shift_op_t;
endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: shift by 2**K when amt[K] is set, registered with valid/ready.
// Rotate muxes exist only when PIPELINED_BARREL_SHIFTER_ROTATE_EN is defined.
module barrel_shift_stage
  import shift_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  shift_op_t            in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_amt,
  output shift_op_t            out_op
);
  localparam int S = 2 ** K;
  logic         r_valid;
  logic [N-1:0] r_data;
  logic [$clog2(N)-1:0] r_amt;
  shift_op_t    r_op;
  logic [N-1:0] w_srl, w_sra, w_sll, w_shifted;
  // Arithmetic shifts keep the MSB, so the data MSB is always the original sign bit.
  assign w_srl = in_data >> S;
  assign w_sra = $signed(in_data) >>> S;
  assign w_sll = in_data << S;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
  logic [N-1:0] w_ror;
  assign w_ror = (in_data >> S) | (in_data << (N - S));
`endif
  always_comb begin
    w_shifted = !in_amt[K]          ? in_data :
                in_op == SHIFT_SRA ? w_sra   :
                in_op == SHIFT_SLL ? w_sll   :
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                in_op == SHIFT_ROR ? w_ror   :
`endif
                w_srl;
  end
  assign in_ready = !r_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_op    <= SHIFT_SRL;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_shifted;
        r_amt  <= in_amt;
        r_op   <= in_op;
      end
    end
  end
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_amt   = r_amt;
  assign out_op    = r_op;
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(N)-stage variable shifter with valid/ready on both sides.
// Define PIPELINED_BARREL_SHIFTER_ROTATE_EN to make op 11 rotate right; otherwise it acts as SRL.
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter int N = 8,
  localparam int STAGES = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [N-1:0]      up_data,
  input  logic [STAGES-1:0] up_amt,
  input  shift_op_t         up_op,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [N-1:0]      down_data
);
  logic              w_valid [STAGES+1];
  logic              w_ready [STAGES+1];
  logic [N-1:0]      w_data  [STAGES+1];
  logic [STAGES-1:0] w_amt   [STAGES+1];
  shift_op_t         w_op    [STAGES+1];
  logic [STAGES+1:0] w_unused_tail;
  assign w_valid[0]      = up_valid;
  assign w_data[0]       = up_data;
  assign w_amt[0]        = up_amt;
  assign w_op[0]         = up_op;
  assign w_ready[STAGES] = down_ready;
  assign up_ready        = w_ready[0];
  assign down_valid      = w_valid[STAGES];
  assign down_data       = w_data[STAGES];
  // The last stage's amt/op have no consumer.
  assign w_unused_tail   = {w_amt[STAGES], w_op[STAGES]};
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    barrel_shift_stage #(.N(N), .K(k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .in_data   (w_data[k]),
      .in_amt    (w_amt[k]),
      .in_op     (w_op[k]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1]),
      .out_data  (w_data[k+1]),
      .out_amt   (w_amt[k+1]),
      .out_op    (w_op[k+1])
    );
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and random checks against a queue-based shift model.
module tb_pipelined_barrel_shifter;
  import shift_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_valid = 1'b0, up_ready, down_valid, down_ready = 1'b0;
  logic [7:0] up_data = '0, down_data;
  logic [2:0] up_amt = '0;
  shift_op_t  up_op = SHIFT_SRL;
  int         checks = 0, errors = 0;
  logic [7:0] q[$];
  logic       acc, hold_pend = 1'b0;
  logic [7:0] hold_data;

  pipelined_barrel_shifter #(.N(8)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_amt(up_amt), .up_op(up_op), .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input shift_op_t o, input logic [7:0] d, input int a);
    logic [15:0] dd;
    dd = {d, d};
    case (o)
      SHIFT_SRL: return d >> a;
      SHIFT_SRA: return 8'($signed(d) >>> a);
      SHIFT_SLL: return d << a;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
      default:   return dd[7:0] >> a | 8'(dd >> a);
`else
      default:   return d >> a;
`endif
    endcase
  endfunction

  task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] a, input shift_op_t o,
                       input logic dr);
    @(negedge clk);
    up_valid = v; up_data = d; up_amt = a; up_op = o; down_ready = dr;
    #1;
    if (hold_pend) begin
      chk("hold_valid", down_valid, 1);
      chk("hold_data", down_data, hold_data);
    end
    acc = v && up_ready;
    if (acc) q.push_back(model(o, d, a));
    if (down_valid && dr) begin
      if (q.size() == 0) chk("underflow", 32'(q.size()), 1);
      else chk("stream", down_data, q.pop_front());
    end
    hold_pend = down_valid && !dr;
    hold_data = down_data;
  endtask

  task automatic run_one(input string tag, input shift_op_t o, input logic [7:0] d,
                         input logic [2:0] a, input logic [7:0] exp);
    cycle(1'b1, d, a, o, 1'b1);
    chk({tag, "_acc"}, acc, 1);
    repeat (2) begin
      cycle(1'b0, 8'h00, 3'd0, SHIFT_SRL, 1'b1);
      chk({tag, "_early"}, down_valid, 0);
    end
    cycle(1'b0, 8'h00, 3'd0, SHIFT_SRL, 1'b1);
    chk({tag, "_valid"}, down_valid, 1);
    chk(tag, down_data, exp);
  endtask

  initial begin
    logic       v, pv;
    logic [7:0] d;
    logic [2:0] a;
    shift_op_t  o;
    int         n, cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", up_ready, 1);
    chk("rst_valid", down_valid, 0);
    chk("rst_data", down_data, 0);

    run_one("srl", SHIFT_SRL, 8'b1011_0110, 3'd3, 8'b0001_0110);
    run_one("sra", SHIFT_SRA, 8'b1011_0110, 3'd3, 8'b1111_0110);
    run_one("sll", SHIFT_SLL, 8'b1011_0110, 3'd3, 8'b1011_0000);
    run_one("sra_pos7", SHIFT_SRA, 8'b0110_0000, 3'd7, 8'b0000_0000);
    run_one("sra_neg7", SHIFT_SRA, 8'b1000_0000, 3'd7, 8'b1111_1111);
    run_one("sll7", SHIFT_SLL, 8'b1011_0111, 3'd7, 8'b1000_0000);
    run_one("amt0", SHIFT_SRA, 8'b1011_0110, 3'd0, 8'b1011_0110);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
    run_one("ror", SHIFT_ROR, 8'b1011_0110, 3'd3, 8'b1101_0110);
    run_one("ror7", SHIFT_ROR, 8'b1011_0110, 3'd7, 8'b0110_1101);
`else
    run_one("ror", SHIFT_ROR, 8'b1011_0110, 3'd3, 8'b0001_0110);
`endif

    // Backpressure: three fill the pipe, the fourth waits until the consumer is ready.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'(8'h91 + 8'(i * 37)), 3'(i + 1), shift_op_t'(i), 1'b0);
      chk("bp_acc", acc, (i < 3) ? 1 : 0);
    end
    cycle(1'b1, 8'(8'h91 + 8'(3 * 37)), 3'd4, SHIFT_ROR, 1'b1);
    chk("bp_acc4", acc, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 3'd0, SHIFT_SRL, 1'b1);
      chk("bp_release", down_valid, 1);
    end
    cycle(1'b0, 8'h00, 3'd0, SHIFT_SRL, 1'b1);
    chk("bp_empty", down_valid, 0);
    chk("bp_queue", 32'(q.size()), 0);

    // Reset with two items in flight.
    cycle(1'b1, 8'hA5, 3'd1, SHIFT_SLL, 1'b1);
    cycle(1'b1, 8'h5A, 3'd2, SHIFT_SRA, 1'b1);
    @(negedge clk);
    rst = 1'b1; up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("flush_valid", down_valid, 0);
    chk("flush_data", down_data, 0);
    chk("flush_ready", up_ready, 1);
    q.delete();
    hold_pend = 1'b0;
    repeat (4) begin
      cycle(1'b0, 8'h00, 3'd0, SHIFT_SRL, 1'b1);
      chk("flush_gone", down_valid, 0);
    end

    // Random traffic with stalls on both sides.
    n = 0; cyc = 0; pv = 1'b0;
    v = 1'b0; d = '0; a = '0; o = SHIFT_SRL;
    while (n < 1000 && cyc < 20000) begin
      if (!pv) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
        a = 3'($urandom_range(0, 7));
        o = shift_op_t'($urandom_range(0, 3));
      end
      cycle(v, d, a, o, $urandom_range(0, 2) != 0);
      if (acc) n++;
      pv = v && !acc;
      cyc++;
    end
    chk("rand_count", n, 1000);
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, 8'h00, 3'd0, SHIFT_SRL, 1'b1);
    chk("drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
